// File: rtl/mnist_pkg.sv
// Shared MNIST pipeline definitions.
// Widths and defaults for the acc and argmax stages.
package mnist_pkg;

    localparam int ACC_DOUT_W         = 22;
    localparam int ARGMAX_NUM_CLASSES = 10;
    localparam int ARGMAX_ACC_W       = ACC_DOUT_W;
    localparam int ARGMAX_IDX_W       = 4;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/argmax_unit_if.sv
// Argmax stage handshake bundle.
// Input stream, abort and result stream.
interface argmax_unit_if #(
    parameter int ACC_W = 22,
    parameter int IDX_W = 4
);

    logic [ACC_W-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [IDX_W-1:0] class_idx;
    logic [ACC_W-1:0] max_val;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output din, in_valid, clear, out_ready,
        input  in_ready, class_idx, max_val, out_valid
    );

    modport slave (
        input  din, in_valid, clear, out_ready,
        output in_ready, class_idx, max_val, out_valid
    );

endinterface

// File: rtl/argmax_unit.sv
// Argmax over one classification's neuron results.
// Streams NUM_CLASSES samples, holds the winner until taken.
module argmax_unit
    import mnist_pkg::*;
#(
    parameter int NUM_CLASSES = ARGMAX_NUM_CLASSES,
    parameter int ACC_W       = ARGMAX_ACC_W,
    parameter int IDX_W       = ARGMAX_IDX_W
) (
    input logic         clk,
    input logic         rst,
    argmax_unit_if.slave bus
);

    argmax_state_t    state;
    argmax_state_t    state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx_q;
    logic [ACC_W-1:0] max_q;
    logic             xfer;
    logic             take;
    logic             last;
    logic             gt;

    assign bus.in_ready  = rst && (state == ST_COLLECT);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.class_idx = idx_q;
    assign bus.max_val   = max_q;

    assign xfer = bus.in_valid && bus.in_ready;
    assign take = bus.out_valid && bus.out_ready;
    assign last = (cnt == IDX_W'(NUM_CLASSES - 1));
    assign gt   = $signed(bus.din) > $signed(max_q);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; clear overrides both handshakes.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ST_COLLECT;
        end else begin
            unique case (state)
                ST_COLLECT: if (xfer && last) state_nxt = ST_DONE;
                ST_DONE:    if (take)         state_nxt = ST_COLLECT;
                default:    state_nxt = ST_COLLECT;
            endcase
        end
    end

    // Sample counter and running max/index; first sample seeds the max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx_q <= '0;
            max_q <= '0;
        end else if (bus.clear) begin
            cnt <= '0;
        end else if (xfer) begin
            if (cnt == '0) begin
                max_q <= bus.din;
                idx_q <= '0;
            end else if (gt) begin
                max_q <= bus.din;
                idx_q <= cnt;
            end
            cnt <= last ? '0 : cnt + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit.
// Hand-computed winners for fixed sample sets.
module tb_argmax_unit;

    localparam int ACC_W = 22;
    localparam int IDX_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   vec [10];

    argmax_unit_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

    argmax_unit #(
        .NUM_CLASSES(10),
        .ACC_W      (ACC_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sval();
        return longint'($signed(bus.max_val));
    endfunction

    // Feed vec continuously, then check the held result.
    task automatic run_set(input string tag, input int eidx, input int emax);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) check({tag, "_ov_early"}, longint'(bus.out_valid), 0);
            bus.in_valid = 1'b1;
            bus.din      = ACC_W'(vec[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_ov"},  longint'(bus.out_valid), 1);
        check({tag, "_ir"},  longint'(bus.in_ready), 0);
        check({tag, "_idx"}, longint'(bus.class_idx), longint'(eidx));
        check({tag, "_max"}, sval(), longint'(emax));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_taken"}, longint'(bus.out_valid), 0);
        check({tag, "_ir_back"}, longint'(bus.in_ready), 1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.din       = '0;
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ir",  longint'(bus.in_ready), 0);
        check("rst_ov",  longint'(bus.out_valid), 0);
        check("rst_idx", longint'(bus.class_idx), 0);
        check("rst_max", sval(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ir", longint'(bus.in_ready), 1);

        vec = '{1, 2, 3, 4, -3, 2, -5, -10, 7, 0};
        run_set("basic", 8, 7);
        consume("basic");

        vec = '{-1, -1, -1, -2, -1, -1, -1, -1, -1, -1};
        run_set("tie", 0, -1);
        consume("tie");

        vec = '{0, 0, 0, 0, 0, 2097151, -2097152, 0, 0, 0};
        run_set("ext", 5, 2097151);
        consume("ext");

        vec = '{-4, 9, 3, 9, 1, 0, 2, 8, -9, 5};
        run_set("bp", 1, 9);
        bus.in_valid = 1'b1;
        bus.din      = ACC_W'(100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ir",  longint'(bus.in_ready), 0);
            check("bp_ov",  longint'(bus.out_valid), 1);
            check("bp_idx", longint'(bus.class_idx), 1);
            check("bp_max", sval(), 9);
        end
        bus.in_valid = 1'b0;
        consume("bp");
        vec = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        run_set("bp_next", 0, 9);
        consume("bp_next");

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.din      = ACC_W'(50);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_ir",  longint'(bus.in_ready), 0);
        check("mid_rst_ov",  longint'(bus.out_valid), 0);
        check("mid_rst_idx", longint'(bus.class_idx), 0);
        check("mid_rst_max", sval(), 0);
        @(negedge clk);
        rst = 1'b1;
        vec = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_set("after_rst", 9, 9);
        consume("after_rst");

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.din      = ACC_W'(1000);
        end
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.din      = ACC_W'(5000);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_ov", longint'(bus.out_valid), 0);
        vec = '{-4, -8, 6, 2, 6, -1, 0, 5, -9, 1};
        run_set("clr", 2, 6);

        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clr_done_ov", longint'(bus.out_valid), 0);
        check("clr_done_ir", longint'(bus.in_ready), 1);
        vec = '{-3, -7, -2, -6, -2, -9, -8, -5, -4, -3};
        run_set("clr_done_next", 2, -2);
        consume("clr_done_next");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/argmax_unit.md
ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, the number of output-layer neuron results per classification.
REQ-002 The block SHALL have parameter ACC_W, default 22, the signed width of each incoming accumulator result.
REQ-003 The block SHALL have parameter IDX_W, default 4, the class-index width, with 2^IDX_W >= NUM_CLASSES.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port din, input, ACC_W bits, a two's-complement accumulator result from the upstream acc stage.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning din holds a valid result.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts din this cycle.
REQ-009 The block SHALL have port clear, input, 1 bit, a synchronous abort that discards the partial classification.
REQ-010 The block SHALL have port class_idx, output, IDX_W bits, the winning class index.
REQ-011 The block SHALL have port max_val, output, ACC_W bits, the signed winning value.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning class_idx and max_val are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.

Function
REQ-014 The block SHALL accept a sample only on a cycle where in_valid and in_ready are both high (a transfer).
REQ-015 The block SHALL implement two states: COLLECT, with in_ready=1 and out_valid=0, and DONE, with in_ready=0 and out_valid=1.
REQ-016 In COLLECT, the block SHALL keep a sample counter 0..NUM_CLASSES-1 that increments on each transfer; the counter value is that sample's class index.
REQ-017 On a transfer with counter=0, the block SHALL load the running max with din and the running index with 0, regardless of their prior contents.
REQ-018 On a transfer with counter>0, the block SHALL replace the running max and index only if din is strictly greater, using a full-width signed compare.
REQ-019 Ties SHALL keep the lowest index.
REQ-020 The block SHALL perform no saturation or truncation.
REQ-021 On the transfer with counter=NUM_CLASSES-1, the block SHALL enter DONE on the next edge, with out_valid high and class_idx/max_val already including that sample (1-cycle latency), and SHALL reset the counter to 0.
REQ-022 In DONE, class_idx, max_val and out_valid SHALL remain stable until out_valid and out_ready are both high; the block SHALL then return to COLLECT on the next edge.
REQ-023 In DONE, in_valid SHALL be ignored; upstream is back-pressured, so no sample is lost or double-counted.
REQ-024 clear in COLLECT SHALL zero the counter and stay in COLLECT.
REQ-025 clear in DONE SHALL drop the result (out_valid=0) and return to COLLECT.
REQ-026 clear SHALL take priority over a simultaneous transfer or output handshake; the concurrent sample SHALL be discarded.
REQ-027 class_idx and max_val SHALL be driven directly from registers, with no combinational path from din.

Reset
REQ-028 rst low SHALL asynchronously force state=COLLECT, counter=0, class_idx=0, max_val=0 and out_valid=0.
REQ-029 While rst is low, in_ready SHALL be 0.
REQ-030 Deassertion of rst SHALL take effect on the next clk edge.
REQ-031 A reset mid-collection SHALL discard all partial samples.

Structure
REQ-032 NUM_CLASSES, ACC_W and IDX_W defaults SHALL live in the shared mnist_pkg package alongside the acc widths (ACC_W equals the acc dout width).
REQ-033 The state encoding SHALL be a typedef in mnist_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the compare is inline.

Verification
REQ-035 Scenario: din = 1,2,3,4,-3,2,-5,-10,7,0 with in_valid continuous -> out_valid one cycle after the 10th transfer, class_idx=8, max_val=7.
REQ-036 Scenario: all ten samples = -1 except index 3 = -2 -> class_idx=0, max_val=-1 (tie, lowest index; negative initialisation correct).
REQ-037 Scenario: extremes, index 5 = 2^21-1 and index 6 = -2^21 -> class_idx=5, max_val=2097151.
REQ-038 Scenario: out_ready held low 5 cycles after DONE with in_valid high -> in_ready=0 and outputs unchanged throughout; the next set of 10 samples yields its own correct result.
REQ-039 Scenario: rst asserted after 4 transfers, then 10 fresh samples 0..9 -> class_idx=9, max_val=9, with all outputs 0 during reset.
REQ-040 Scenario: clear after 6 transfers, asserted together with in_valid -> that sample is discarded and the next 10 transfers alone determine the result.
